keypad_scan_encoder: RTL

Scans a 4x4 active-low matrix keypad, debounces the full key map, and encodes a single debounced key press into a 4-bit hex code with a one-cycle valid strobe. It is the input-side counterpart of the segment display path: its `key_code` output is the 4-bit nibble source for the board's segment decoder, replacing raw switch inputs. It sits directly behind the keypad pins and in front of any display or control logic.

---
 rtl/keypad_scan_encoder.sv | 112 +++++++++++
 1 files changed

// File: rtl/keypad_scan_encoder.sv
// keypad_scan_encoder: 4x4 active-low keypad scanner with full-map
// debounce and single-key hex encoder.
module keypad_scan_encoder #(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_down
);

  localparam logic [15:0] DIV_LAST = 16'(SCAN_DIV - 1);
  localparam logic [3:0]  DB_N     = 4'(DEBOUNCE_SCANS);

  logic [3:0]  row_s1;
  logic [3:0]  row_s2;
  logic [15:0] div;
  logic [1:0]  ci;
  logic [1:0]  ci_nxt;
  logic [15:0] snap;
  logic [15:0] prev;
  logic [15:0] stable;
  logic [3:0]  match;

  logic        slot_end;
  logic        scan_end;
  logic [15:0] snap_nxt;
  logic [3:0]  match_nxt;
  logic [3:0]  new_idx;
  logic        snap_one;
  logic        stable_upd;
  logic        press;

  assign slot_end = (div == DIV_LAST);
  assign scan_end = slot_end && (ci == 2'd3);
  assign ci_nxt   = ci + 2'd1;

  // Only the four bits of the column being driven are refreshed.
  always_comb begin
    snap_nxt = snap;
    snap_nxt[{2'd0, ci}] = ~row_s2[0];
    snap_nxt[{2'd1, ci}] = ~row_s2[1];
    snap_nxt[{2'd2, ci}] = ~row_s2[2];
    snap_nxt[{2'd3, ci}] = ~row_s2[3];
  end

  always_comb begin
    new_idx = '0;
    for (int i = 0; i < 16; i++) begin
      if (snap_nxt[i]) new_idx = 4'(i);
    end
  end

  assign match_nxt = (snap_nxt == prev)
                   ? ((match >= DB_N) ? DB_N : match + 4'd1)
                   : 4'd1;

  assign snap_one = (snap_nxt != '0) &&
                    ((snap_nxt & (snap_nxt - 16'd1)) == '0);

  assign stable_upd = scan_end && (match_nxt == DB_N) &&
                      (snap_nxt != stable);

  // A press is reported only when leaving a fully released map.
  assign press = stable_upd && snap_one && (stable == '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      row_s1    <= 4'b1111;
      row_s2    <= 4'b1111;
      div       <= '0;
      ci        <= '0;
      col       <= 4'b1110;
      snap      <= '0;
      prev      <= '0;
      stable    <= '0;
      match     <= '0;
      key_code  <= '0;
      key_valid <= 1'b0;
      key_down  <= 1'b0;
    end else begin
      row_s1    <= row;
      row_s2    <= row_s1;
      key_valid <= 1'b0;
      if (slot_end) begin
        div  <= '0;
        ci   <= ci_nxt;
        col  <= ~(4'b0001 << ci_nxt);
        snap <= snap_nxt;
      end else begin
        div <= div + 16'd1;
      end
      if (scan_end) begin
        match <= match_nxt;
        prev  <= snap_nxt;
      end
      if (stable_upd) begin
        stable   <= snap_nxt;
        key_down <= snap_one;
      end
      if (press) begin
        key_valid <= 1'b1;
        key_code  <= new_idx;
      end
    end
  end

endmodule
